// File: rtl/core_mc_if.sv
// core_mc_if: instruction handshake, global register bus and accumulator of one shader lane
interface core_mc_if #(
  parameter int BIT_WIDTH      = 8,
  parameter int NR_GLOBAL_REGS = 9
);
  logic [15:0]                          opcode;
  logic                                 execute;
  logic                                 ready;
  logic [NR_GLOBAL_REGS*BIT_WIDTH-1:0]  global_registers_in;
  logic [2*BIT_WIDTH-1:0]               accu;
  modport master (output opcode, execute, global_registers_in, input ready, accu);
  modport slave  (input opcode, execute, global_registers_in, output ready, accu);
endinterface

// File: rtl/core_mc.sv
// core_mc: SIMD shader lane with 2W accumulator, local regs and shift-add multiplier; CORE_SAT_EN enables saturation
module core_mc #(
  parameter int CORE_ID        = 0,
  parameter int BIT_WIDTH      = 8,
  parameter int NR_LOCAL_REGS  = 8,
  parameter int NR_GLOBAL_REGS = 9
) (
  input  logic       clk,
  input  logic       reset,
  core_mc_if.slave   bus
);
  localparam int W  = BIT_WIDTH;
  localparam int AW = 2 * W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [AW-1:0] MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW-1:0] MAX = ~MIN;
  typedef enum logic {IDLE, MUL} state_t;
  state_t            state_q;
  logic [W-1:0]      loc_q [NR_LOCAL_REGS];
  logic [AW-1:0]     accu_q, mcand_q, prod_q;
  logic [W-1:0]      mplier_q;
  logic [CW-1:0]     cnt_q;
  logic              ready_q;
  logic [15:0]       op;
  logic [NR_GLOBAL_REGS*W-1:0] glob;
  logic [4:0]        ra, rb;
  logic [W-1:0]      ra_val, rb_val, wr_data;
  logic [AW-1:0]     op0, op1, add_r, shl_r, neg_r, un_r, prod_n;
  logic [AW:0]       sum;
  logic              accept, wr_en;
  assign op       = bus.opcode;
  assign glob     = bus.global_registers_in;
  assign bus.ready = ready_q;
  assign bus.accu  = accu_q;
  function automatic logic [W-1:0] rd(input logic [4:0] idx, input logic [NR_GLOBAL_REGS*W-1:0] g_in);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NR_LOCAL_REGS; i++)
      if (idx == 5'(i)) r = loc_q[i];
    if (idx == 5'd15) r = W'(CORE_ID);
    for (int g = 0; g < NR_GLOBAL_REGS; g++)
      if (idx == 5'(16 + g)) r = g_in[g*W +: W];
    return r;
  endfunction
  function automatic logic [AW-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction
  // Operand fetch, ALU results and register-file write decode for the offered instruction
  always_comb begin
    accept  = bus.execute & ready_q;
    ra      = op[13:9];
    rb      = {1'b0, op[8:5]};
    ra_val  = rd(ra, glob);
    rb_val  = rd(rb, glob);
    op0     = op[2] ? accu_q : sext(ra_val);
    op1     = op[3] ? accu_q : sext(rb_val);
    sum     = op[0] ? {op0[AW-1], op0} - {op1[AW-1], op1} : {op0[AW-1], op0} + {op1[AW-1], op1};
`ifdef CORE_SAT_EN
    add_r   = (sum[AW] != sum[AW-1]) ? (sum[AW] ? MIN : MAX) : sum[AW-1:0];
    shl_r   = (accu_q[AW-1] != accu_q[AW-2]) ? (accu_q[AW-1] ? MIN : MAX) : accu_q << 1;
    neg_r   = (accu_q == MIN) ? MAX : -accu_q;
`else
    add_r   = sum[AW-1:0];
    shl_r   = accu_q << 1;
    neg_r   = -accu_q;
`endif
    un_r    = (op[2:0] == 3'd0) ? '0 :
              (op[2:0] == 3'd1) ? shl_r :
              (op[2:0] == 3'd2) ? AW'($signed(accu_q) >>> 1) :
              (op[2:0] == 3'd3) ? neg_r :
              (op[2:0] == 3'd4) ? (accu_q[AW-1] ? -accu_q : accu_q) : accu_q;
    prod_n  = prod_q + (mplier_q[0] ? mcand_q : '0);
    wr_en   = accept & ((op[15:14] == 2'b00) | ((op[15:14] == 2'b11) & (op[8] | op[7])));
    wr_data = (op[15:14] == 2'b00) ? W'(op[7:0]) : op[8] ? accu_q[W-1:0] : accu_q[AW-1:W];
  end
  // Local register file; writes to indices outside the local range fall through every compare
  always_ff @(posedge clk)
    for (int i = 0; i < NR_LOCAL_REGS; i++)
      if (reset) loc_q[i] <= '0;
      else if (wr_en && ra == 5'(i)) loc_q[i] <= wr_data;
  // Control FSM: single-cycle accumulator ops in IDLE, one multiplier bit per cycle in MUL
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      accu_q   <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (state_q == MUL) begin
      prod_q   <= prod_n;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        accu_q  <= prod_n;
        ready_q <= 1'b1;
        state_q <= IDLE;
      end
    end else if (accept) begin
      if (op[15:14] == 2'b01 && op[1]) begin
        state_q  <= MUL;
        ready_q  <= 1'b0;
        cnt_q    <= '0;
        prod_q   <= '0;
        mcand_q  <= {{W{1'b0}}, ra_val};
        mplier_q <= rb_val;
      end else if (op[15:14] == 2'b01) begin
        accu_q <= add_r;
      end else if (op[15:14] == 2'b10) begin
        accu_q <= un_r;
      end
    end
  end
endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: directed scoreboard bench for core_mc (BIT_WIDTH=8, defaults; honours CORE_SAT_EN)
module tb_core_mc;
  typedef struct {string name; logic [15:0] accu; int lat;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic [15:0] sat_v;
  core_mc_if #(.BIT_WIDTH(8), .NR_GLOBAL_REGS(9)) bus ();
  core_mc #(.CORE_ID(0), .BIT_WIDTH(8), .NR_LOCAL_REGS(8), .NR_GLOBAL_REGS(9)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  localparam logic [4:0] ADD = 5'b00000, SUB_ACC = 5'b00101, MULT = 5'b00010, ACC2 = 5'b01100;
  function automatic logic [15:0] ld(int ra, logic [7:0] imm);
    return {2'b00, 5'(ra), 1'b0, imm};
  endfunction
  function automatic logic [15:0] bin(int ra, int rb, logic [4:0] lo);
    return {2'b01, 5'(ra), 4'(rb), lo};
  endfunction
  function automatic logic [15:0] un(int code);
    return {2'b10, 11'b0, 3'(code)};
  endfunction
  function automatic logic [15:0] st(int ra, bit hi);
    return {2'b11, 5'(ra), ~hi, hi, 7'b0};
  endfunction
  task automatic drive(input logic [15:0] op);
    @(negedge clk);
    bus.opcode  = op;
    bus.execute = 1'b1;
    @(posedge clk);
    #1 bus.execute = 1'b0;
  endtask
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 50) begin n++; @(negedge clk); end
    if (!bus.ready) begin total++; bad++; $display("FAIL wait_ready: ready=%b required 1", bus.ready); end
  endtask
  task automatic issue(input string name, input logic [15:0] op, input logic [15:0] ea, input int lat, input bit nowait = 0);
    exp_t e;
    e.name = name; e.accu = ea; e.lat = lat;
    q.push_back(e);
    drive(op);
    if (!nowait) wait_ready();
  endtask
  task automatic set_g(input int g, input logic [7:0] v);
    bus.global_registers_in[g*8 +: 8] = v;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && bus.execute && bus.ready) begin
        int lat;
        exp_t e;
        lat = 0;
        @(negedge clk);
        while (!bus.ready && lat < 100) begin lat++; @(negedge clk); end
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected: response accu=%h with no expectation", bus.accu);
        end else begin
          e = q.pop_front();
          total += 2;
          if (bus.accu !== e.accu) begin bad++; $display("FAIL %s accu: got %h required %h", e.name, bus.accu, e.accu); end
          if (lat != e.lat) begin bad++; $display("FAIL %s latency: got %0d required %0d", e.name, lat, e.lat); end
        end
      end
    end
  end
  initial begin
`ifdef CORE_SAT_EN
    sat_v = 16'h7FFF;
`else
    sat_v = 16'hFC04;
`endif
    bus.opcode = '0;
    bus.execute = 1'b0;
    bus.global_registers_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 2;
    if (bus.accu !== 16'h0000) begin bad++; $display("FAIL reset accu: got %h required 0000", bus.accu); end
    if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset ready: got %b required 1", bus.ready); end
    reset = 1'b0;
    issue("ld_r3", ld(3, 8'h05), 16'h0000, 0);
    issue("ld_r4", ld(4, 8'h07), 16'h0000, 0);
    issue("mul_5x7", bin(3, 4, MULT), 16'h0023, 8);
    issue("ld_r0", ld(0, 8'hFE), 16'h0023, 0);
    issue("ld_r1", ld(1, 8'h03), 16'h0023, 0);
    issue("add_r0_r1", bin(0, 1, ADD), 16'h0001, 0);
    issue("sub_acc_r1", bin(0, 1, SUB_ACC), 16'hFFFE, 0);
    issue("mul_busy", bin(3, 4, MULT), 16'h0023, 8, 1);
    @(negedge clk);
    drive(ld(2, 8'h11));
    wait_ready();
    issue("r2_unchanged", bin(2, 14, ADD), 16'h0000, 0);
    issue("ld_r2", ld(2, 8'h11), 16'h0000, 0);
    issue("r2_loaded", bin(2, 14, ADD), 16'h0011, 0);
    set_g(0, 8'h42);
    issue("mul_glob", bin(16, 3, MULT), 16'h014A, 8, 1);
    @(negedge clk);
    set_g(0, 8'h10);
    wait_ready();
    issue("glob_new", bin(16, 14, ADD), 16'h0010, 0);
    set_g(8, 8'h81);
    issue("glob_last", bin(24, 14, ADD), 16'hFF81, 0);
    issue("glob_beyond", bin(25, 14, ADD), 16'h0000, 0);
    issue("ld_r9_drop", ld(9, 8'h33), 16'h0000, 0);
    issue("r9_reads0", bin(9, 14, ADD), 16'h0000, 0);
    issue("core_id", bin(15, 14, ADD), 16'h0000, 0);
    issue("mul_reset", bin(3, 4, MULT), 16'h0000, 4, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    issue("r3_cleared", bin(3, 14, ADD), 16'h0000, 0);
    issue("ld_r0_2", ld(0, 8'h02), 16'h0000, 0);
    issue("add_post_rst", bin(0, 0, ADD), 16'h0004, 0);
    issue("ld_r7", ld(7, 8'h7F), 16'h0004, 0);
    issue("mul_7f", bin(7, 7, MULT), 16'h3F01, 8);
    issue("acc_x2", bin(0, 0, ACC2), 16'h7E02, 0);
    issue("acc_x2_ovf", bin(0, 0, ACC2), sat_v, 0);
    issue("ld_r3b", ld(3, 8'h05), sat_v, 0);
    issue("ld_r4b", ld(4, 8'h07), sat_v, 0);
    issue("mul_5x7b", bin(3, 4, MULT), 16'h0023, 8);
    issue("neg", un(3), 16'hFFDD, 0);
    issue("st_lo_r5", st(5, 1'b0), 16'hFFDD, 0);
    issue("st_hi_r6", st(6, 1'b1), 16'hFFDD, 0);
    issue("r5_val", bin(5, 14, ADD), 16'hFFDD, 0);
    issue("r6_val", bin(6, 14, ADD), 16'hFFFF, 0);
    set_g(0, 8'h42);
    issue("g0_add", bin(16, 14, ADD), 16'h0042, 0);
    issue("shl", un(1), 16'h0084, 0);
    issue("asr", un(2), 16'h0042, 0);
    issue("un_nop", un(7), 16'h0042, 0);
    issue("ld_r0_80", ld(0, 8'h80), 16'h0042, 0);
    issue("sext_80", bin(0, 14, ADD), 16'hFF80, 0);
    issue("asr_neg", un(2), 16'hFFC0, 0);
    issue("abs", un(4), 16'h0040, 0);
    issue("clr", un(0), 16'h0000, 0);
    issue("st_nop", {2'b11, 5'd1, 9'b0}, 16'h0000, 0);
    issue("ld_r1_ff", ld(1, 8'hFF), 16'h0000, 0);
    issue("mul_ff", bin(1, 1, MULT), 16'hFE01, 8);
    issue("mul_zero", bin(1, 14, MULT), 16'h0000, 8);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin total++; bad++; $display("FAIL leftover: pending=%0d required 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
